// File: rtl/intc_cpu_ack.sv
// CPU-side responder for the interrupt selector: masks the selected request,
// handshakes it with the core, then returns intack-all and per-source ack pulses.
module intc_cpu_ack #(
    parameter int          REG_NUM  = 1,
    parameter logic [7:0]  VEC_BASE = 8'd64,
    parameter int          HOLD_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sl_req_i,
    input  logic [4:0]              sl_level_i,
    input  logic [7:0]              sl_vec_i,
    input  logic [3:0]              cpu_imask_i,
    input  logic                    cpu_ack_i,
    output logic                    cpu_int_o,
    output logic [4:0]              cpu_level_o,
    output logic [7:0]              cpu_vec_o,
    output logic                    cp_intack_all_o,
    output logic                    ack_nmi_o,
    output logic                    ack_err_o,
    output logic [REG_NUM*32-1:0]   ack_src_o,
    output logic                    spurious_o,
    output logic                    busy_o
);

    localparam int         NSRC      = REG_NUM * 32;
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [3:0]      hold_cnt_q, hold_cnt_d;
    logic            cpu_int_q, cpu_int_d;
    logic [4:0]      level_q, level_d;
    logic [7:0]      vec_q, vec_d;
    logic            intack_q, intack_d;
    logic            ack_nmi_q, ack_nmi_d;
    logic            ack_err_q, ack_err_d;
    logic [NSRC-1:0] ack_src_q, ack_src_d;
    logic            spurious_q, spurious_d;
    logic            busy_q, busy_d;

    logic            qual_s;
    logic [7:0]      off_s;
    logic            in_rng_s;
    logic            is_nmi_s;
    logic            is_err_s;
    logic            hit_src_s;
    logic            is_spur_s;

    // Request qualification against the CPU mask and decode of the frozen vector
    always_comb begin
        qual_s    = sl_req_i & ((sl_level_i == 5'd16) |
                                (~sl_level_i[4] & (sl_level_i[3:0] > cpu_imask_i)));
        off_s     = vec_q - VEC_BASE;
        // widened compare so VEC_BASE+NSRC never wraps at 8 bits
        in_rng_s  = ({24'd0, vec_q} >= {24'd0, VEC_BASE}) &&
                    ({24'd0, vec_q} < ({24'd0, VEC_BASE} + 32'(NSRC)));
        is_nmi_s  = (vec_q == 8'd11);
        is_err_s  = (vec_q == 8'd9);
        hit_src_s = ~is_nmi_s & ~is_err_s & in_rng_s;
        is_spur_s = ~is_nmi_s & ~is_err_s & ~in_rng_s;
    end

    // Handshake state machine and next-value computation for all registered outputs
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        vec_d      = vec_q;
        ack_nmi_d  = 1'b0;
        ack_err_d  = 1'b0;
        ack_src_d  = '0;
        spurious_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (qual_s) begin
                    state_d = ST_REQ;
                    level_d = sl_level_i;
                    vec_d   = sl_vec_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cpu_ack_i) begin
                    state_d    = ST_ACK;
                    ack_nmi_d  = is_nmi_s;
                    ack_err_d  = is_err_s;
                    spurious_d = is_spur_s;
                    for (int i = 0; i < NSRC; i++) begin
                        ack_src_d[i] = hit_src_s && (32'(off_s) == i);
                    end
                end else if (qual_s) begin
                    state_d = ST_REQ;
                    level_d = sl_level_i;
                    vec_d   = sl_vec_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (HOLD_INIT != 4'd0) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_INIT;
                end else begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 4'd0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q <= 4'd1) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 4'd0;
                end else begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = 4'd0;
            end
        endcase

        cpu_int_d = (state_d == ST_REQ);
        intack_d  = (state_d == ST_ACK) || (state_d == ST_HOLD);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 4'd0;
            cpu_int_q  <= 1'b0;
            level_q    <= 5'd0;
            vec_q      <= 8'd0;
            intack_q   <= 1'b0;
            ack_nmi_q  <= 1'b0;
            ack_err_q  <= 1'b0;
            ack_src_q  <= '0;
            spurious_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cpu_int_q  <= cpu_int_d;
            level_q    <= level_d;
            vec_q      <= vec_d;
            intack_q   <= intack_d;
            ack_nmi_q  <= ack_nmi_d;
            ack_err_q  <= ack_err_d;
            ack_src_q  <= ack_src_d;
            spurious_q <= spurious_d;
            busy_q     <= busy_d;
        end
    end

    assign cpu_int_o       = cpu_int_q;
    assign cpu_level_o     = level_q;
    assign cpu_vec_o       = vec_q;
    assign cp_intack_all_o = intack_q;
    assign ack_nmi_o       = ack_nmi_q;
    assign ack_err_o       = ack_err_q;
    assign ack_src_o       = ack_src_q;
    assign spurious_o      = spurious_q;
    assign busy_o          = busy_q;

endmodule

// File: doc/intc_cpu_ack.md
Name: intc_cpu_ack

Overview:
CPU-side responder for the interrupt selector's request interface (request / level / vector out, intack-all back).
- Qualifies the selected request against the CPU's current interrupt mask.
- Runs a request/accept handshake with the core.
- On accept, returns the intack-all indication and one-cycle per-source acknowledge pulses (NMI, ERR, normal sources), so pending bits clear before the next arbitration.

Parameters:
REG_NUM, 1, number of 32-source interrupt register banks (sources = REG_NUM*32)
VEC_BASE, 8'd64, vector number of normal source 0; source k uses vector VEC_BASE+k
HOLD_CYC, 2, extra cycles intack-all stays high after the ACK cycle (0..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sl_req_i  in  1  selected interrupt request from selector
sl_level_i  in  5  selected level; 16 = NMI/ERR (non-maskable), 0..15 normal
sl_vec_i  in  8  selected vector; 11 = NMI, 9 = ERR
cpu_imask_i  in  4  current CPU interrupt mask level
cpu_ack_i  in  1  core accepts the presented interrupt (single-cycle)
cpu_int_o  out  1  interrupt request to core
cpu_level_o  out  5  level presented to core
cpu_vec_o  out  8  vector presented to core
cp_intack_all_o  out  1  intack-all to selector, gates its request
ack_nmi_o  out  1  one-cycle NMI acknowledge pulse
ack_err_o  out  1  one-cycle ERR acknowledge pulse
ack_src_o  out  REG_NUM*32  one-hot one-cycle normal-source acknowledge
spurious_o  out  1  one-cycle pulse: accepted vector decodes to no source
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Qualify: `qual = sl_req_i & (sl_level_i==16 | (sl_level_i[4]==0 & sl_level_i[3:0] > cpu_imask_i))`. Equal level to mask is not accepted.
- Reset (async): state IDLE; all outputs 0, including cpu_level_o and cpu_vec_o; hold counter 0. Reset mid-handshake abandons the handshake with no ack pulses.
- States:
  - IDLE: if qual, register sl_level_i/sl_vec_i into cpu_level_o/cpu_vec_o, set cpu_int_o, go REQ. Request latency is 1 cycle from qual to cpu_int_o.
  - REQ:
    - cpu_ack_i=1: go ACK; clear cpu_int_o; keep cpu_level_o/cpu_vec_o frozen.
    - else if qual: stay in REQ; reload cpu_level_o/cpu_vec_o from sl_* every cycle, so a higher-priority arrival replaces the presented one.
    - else (withdrawn or now masked): clear cpu_int_o, go IDLE, no ack pulses.
    - cpu_ack_i and loss of qual in the same cycle: ack wins.
  - ACK (exactly 1 cycle):
    - cp_intack_all_o=1.
    - Decode the frozen cpu_vec_o:
      - 11 -> ack_nmi_o.
      - 9 -> ack_err_o.
      - VEC_BASE <= v < VEC_BASE+REG_NUM*32 -> ack_src_o[v-VEC_BASE].
      - Otherwise spurious_o.
    - Exactly one of these four pulses is high.
    - Go HOLD (counter = HOLD_CYC) if HOLD_CYC > 0, else IDLE.
  - HOLD: cp_intack_all_o=1; decrement counter each cycle; go IDLE when counter reaches 1. No qual sampling in HOLD.
- cp_intack_all_o is high for exactly 1+HOLD_CYC consecutive cycles per accepted interrupt, then low for at least 1 cycle (the IDLE cycle) before the next cpu_int_o.
- cpu_ack_i outside REQ is ignored (no pulses, no state change).
- Index arithmetic: compute v-VEC_BASE at 8 bits. The range check precedes indexing, so an out-of-range vector never indexes ack_src_o.
- cpu_level_o/cpu_vec_o hold their last value in IDLE and HOLD; they are only meaningful while cpu_int_o=1.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
1. imask=3, sl_req=1, level=5, vec=64+7, then cpu_ack after 2 cycles.
   - cpu_int_o=1 one cycle after req, with level 5 / vec 71.
   - After ack: ack_src_o=1<<7 for 1 cycle, cp_intack_all_o high 3 cycles, busy_o low afterwards.
2. imask=5, level=5 request -> cpu_int_o stays 0. Raise to level 6 -> cpu_int_o=1 next cycle.
3. NMI: level=16, vec=11, imask=15 -> cpu_int_o=1. On ack, ack_nmi_o pulses once; ack_err_o and ack_src_o stay 0.
4. In REQ with level 4 / vec 66, selector switches to level 9 / vec 70.
   - cpu_vec_o becomes 70 next cycle.
   - Ack -> ack_src_o bit 6 only.
5. Withdrawal: in REQ, drop sl_req_i with cpu_ack_i=0 -> cpu_int_o=0 next cycle, no pulses. Repeat with cpu_ack_i=1 in the drop cycle -> ack pulses still issued.
6. vec=200 accepted -> spurious_o pulse, ack_src_o=0. Assert rst during HOLD -> all outputs 0 immediately, cp_intack_all_o low.
